// File: rtl/cpu_types_pkg.sv
// Shared CPU bring-up types: data word, ALU opcode and the operand-entry
// sequence states shown on the board LEDs.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'h0,
        ALU_SRL  = 4'h1,
        ALU_ADD  = 4'h2,
        ALU_SUB  = 4'h3,
        ALU_AND  = 4'h4,
        ALU_OR   = 4'h5,
        ALU_XOR  = 4'h6,
        ALU_NOR  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } aluop_t;

    // Entry sequence, encoded 0..5 in the order the operator walks through it.
    typedef enum logic [2:0] {
        LOAD_A_LO = 3'd0,
        LOAD_A_HI = 3'd1,
        LOAD_B_LO = 3'd2,
        LOAD_B_HI = 3'd3,
        LOAD_OP   = 3'd4,
        SHOW      = 3'd5
    } entry_state_t;

    localparam int KEY_ENTER = 0;
    localparam int KEY_CLEAR = 1;
    localparam int NUM_KEYS  = 2;

    // Low half-word with the upper half filled by the sign-fill switch.
    function automatic word_t fill_low_half(input logic [15:0] data, input logic fill);
        return {{16{fill}}, data};
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizer plus debounce for one active-low pushbutton.
// The accepted level only moves after the synchronized input has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles; a press (1->0 acceptance)
// yields a single-cycle press_pulse in the cycle following the flip.
module key_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RST,
    input  logic key_n,
    output logic level,
    output logic press_pulse
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   level_q;
    logic                   press_q;
    logic                   synced;

    assign synced      = sync_q[SYNC_STAGES-1];
    assign level       = level_q;
    assign press_pulse = press_q;

    // Sync chain, stability counter, accepted level and press pulse; reset treats the key as released.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync_q[0] <= key_n;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            press_q <= 1'b0;
            if (synced != level_q) begin
                if (cnt_q == CNT_MAX) begin
                    level_q <= synced;
                    cnt_q   <= '0;
                    press_q <= ~synced;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/alu_entry_ctrl.sv
// Operand/opcode entry controller for the DE2 ALU bring-up.
// ENTER steps through A low/high, B low/high and opcode capture from the
// switches; CLEAR restarts the sequence and zeroes everything captured.
// All outputs come straight from registers.
module alu_entry_ctrl
    import cpu_types_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  KEY,
    input  logic [17:0] SW,
    output logic [31:0] port_a,
    output logic [31:0] port_b,
    output logic [3:0]  aluop,
    output logic        operands_valid,
    output logic [2:0]  entry_state
);

    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .CLK         (CLK),
            .RST         (RST),
            .key_n       (KEY[k]),
            .level       (key_level[k]),
            .press_pulse (key_press[k])
        );
    end

    // KEY[3:2] are unused and the debounced levels are not needed here.
    logic unused_inputs;
    assign unused_inputs = ^{KEY[3:2], key_level};

    logic enter_pulse;
    logic clear_pulse;
    assign enter_pulse = key_press[KEY_ENTER];
    assign clear_pulse = key_press[KEY_CLEAR];

    logic         skip_hi;
    logic         sign_fill;
    logic [15:0]  sw_data;
    assign skip_hi   = SW[17];
    assign sign_fill = SW[16];
    assign sw_data   = SW[15:0];

    entry_state_t state_q, state_d;
    word_t        port_a_q;
    word_t        port_b_q;
    aluop_t       aluop_q;
    logic         valid_q;

    // Next entry state: CLEAR overrides ENTER; otherwise ENTER advances, skipping high halves on request.
    always_comb begin
        state_d = state_q;
        if (clear_pulse) begin
            state_d = LOAD_A_LO;
        end else if (enter_pulse) begin
            case (state_q)
                LOAD_A_LO: state_d = skip_hi ? LOAD_B_LO : LOAD_A_HI;
                LOAD_A_HI: state_d = LOAD_B_LO;
                LOAD_B_LO: state_d = skip_hi ? LOAD_OP : LOAD_B_HI;
                LOAD_B_HI: state_d = LOAD_OP;
                LOAD_OP:   state_d = SHOW;
                SHOW:      state_d = LOAD_A_LO;
                default:   state_d = LOAD_A_LO;
            endcase
        end
    end

    // State register, capture registers and the registered valid flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= LOAD_A_LO;
            port_a_q <= '0;
            port_b_q <= '0;
            aluop_q  <= aluop_t'(4'h0);
            valid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d == SHOW);
            if (clear_pulse) begin
                port_a_q <= '0;
                port_b_q <= '0;
                aluop_q  <= aluop_t'(4'h0);
            end else if (enter_pulse) begin
                case (state_q)
                    LOAD_A_LO: port_a_q        <= fill_low_half(sw_data, sign_fill);
                    LOAD_A_HI: port_a_q[31:16] <= sw_data;
                    LOAD_B_LO: port_b_q        <= fill_low_half(sw_data, sign_fill);
                    LOAD_B_HI: port_b_q[31:16] <= sw_data;
                    LOAD_OP:   aluop_q         <= aluop_t'(SW[3:0]);
                    default:   ;
                endcase
            end
        end
    end

    assign port_a         = port_a_q;
    assign port_b         = port_b_q;
    assign aluop          = aluop_q;
    assign operands_valid = valid_q;
    assign entry_state    = state_q;

endmodule

// File: tb/tb_alu_entry_ctrl.sv
// Bench for alu_entry_ctrl with a short debounce window. The driver issues
// key presses with hand-computed expected output snapshots pushed into a
// queue; a monitor pops one entry whenever any output changes.
module tb_alu_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  key;
  logic [17:0] sw;
  logic [31:0] port_a;
  logic [31:0] port_b;
  logic [3:0]  aluop;
  logic        operands_valid;
  logic [2:0]  entry_state;

  int checks = 0;
  int failures = 0;
  int resp_idx = 0;
  logic [71:0] exp_q[$];
  logic [71:0] prev_snap;
  logic [71:0] cur_snap;
  logic [71:0] exp_item;
  bit mon_en = 1'b0;

  alu_entry_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .SYNC_STAGES     (2)
  ) dut (
    .CLK            (clk),
    .RST            (rst),
    .KEY            (key),
    .SW             (sw),
    .port_a         (port_a),
    .port_b         (port_b),
    .aluop          (aluop),
    .operands_valid (operands_valid),
    .entry_state    (entry_state)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [71:0] snap(input logic [2:0] st, input logic v,
                                       input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    return {st, v, op, a, b};
  endfunction

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Press the masked keys for a stable window with switches set, then release.
  task automatic press(input logic [3:0] mask, input logic [17:0] swv, input logic [71:0] exp);
    sw = swv;
    exp_q.push_back(exp);
    key = key & ~mask;
    repeat (12) @(posedge clk);
    #1;
    key = 4'hF;
    repeat (12) @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      cur_snap = snap(entry_state, operands_valid, aluop, port_a, port_b);
      if (cur_snap !== prev_snap) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change: got st=%0d v=%0b op=%h a=%h b=%h with no response expected",
                   cur_snap[71:69], cur_snap[68], cur_snap[67:64], cur_snap[63:32], cur_snap[31:0]);
        end else begin
          exp_item = exp_q.pop_front();
          if (cur_snap !== exp_item) begin
            failures++;
            $display("FAIL resp%0d: got st=%0d v=%0b op=%h a=%h b=%h, expected st=%0d v=%0b op=%h a=%h b=%h",
                     resp_idx, cur_snap[71:69], cur_snap[68], cur_snap[67:64], cur_snap[63:32], cur_snap[31:0],
                     exp_item[71:69], exp_item[68], exp_item[67:64], exp_item[63:32], exp_item[31:0]);
          end
        end
        resp_idx++;
        prev_snap = cur_snap;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bit done;
    logic [2:0] start_state;

    rst = 1'b1;
    key = 4'hF;
    sw  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_val("reset_port_a", port_a, 32'h0);
    check_val("reset_port_b", port_b, 32'h0);
    check_val("reset_aluop", {28'h0, aluop}, 32'h0);
    check_val("reset_valid", {31'h0, operands_valid}, 32'h0);
    check_val("reset_state", {29'h0, entry_state}, 32'd0);
    @(posedge clk);
    #1;
    prev_snap = snap(entry_state, operands_valid, aluop, port_a, port_b);
    mon_en = 1'b1;

    // Full entry sequence
    press(4'b0001, {2'b00, 16'h1234}, snap(3'd1, 1'b0, 4'h0, 32'h00001234, 32'h00000000));
    press(4'b0001, {2'b00, 16'hDEAD}, snap(3'd2, 1'b0, 4'h0, 32'hDEAD1234, 32'h00000000));
    press(4'b0001, {2'b00, 16'h0001}, snap(3'd3, 1'b0, 4'h0, 32'hDEAD1234, 32'h00000001));
    press(4'b0001, {2'b00, 16'h0000}, snap(3'd4, 1'b0, 4'h0, 32'hDEAD1234, 32'h00000001));
    press(4'b0001, {2'b00, 16'h0002}, snap(3'd5, 1'b1, 4'h2, 32'hDEAD1234, 32'h00000001));
    check_val("show_valid", {31'h0, operands_valid}, 32'h1);
    check_val("show_port_a", port_a, 32'hDEAD1234);

    // Wrap-around from SHOW keeps captured values
    press(4'b0001, {2'b00, 16'h0F00}, snap(3'd0, 1'b0, 4'h2, 32'hDEAD1234, 32'h00000001));

    // Short entry with sign fill, high halves skipped
    press(4'b0001, {2'b11, 16'h8000}, snap(3'd2, 1'b0, 4'h2, 32'hFFFF8000, 32'h00000001));
    press(4'b0001, {2'b10, 16'h7FFF}, snap(3'd4, 1'b0, 4'h2, 32'hFFFF8000, 32'h00007FFF));
    press(4'b0001, {2'b00, 16'h0005}, snap(3'd5, 1'b1, 4'h5, 32'hFFFF8000, 32'h00007FFF));

    // Bounce rejection: five short low/high bursts, then held low
    sw = '0;
    exp_q.push_back(snap(3'd0, 1'b0, 4'h5, 32'hFFFF8000, 32'h00007FFF));
    for (int i = 0; i < 5; i++) begin
      key[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      key[0] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
    end
    key[0] = 1'b0;
    start_state = entry_state;
    lat = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (entry_state !== start_state) done = 1'b1;
    end
    checks++;
    if (!done || lat < 6 || lat > 9) begin
      failures++;
      $display("FAIL bounce_latency: state changed after %0d cycles (changed=%0b), required 6..9", lat, done);
    end
    repeat (12) @(posedge clk);
    #1;
    key = 4'hF;
    repeat (12) @(posedge clk);
    #1;

    // CLEAR wins over ENTER in the same cycle
    press(4'b0001, {2'b00, 16'hFFFF}, snap(3'd1, 1'b0, 4'h5, 32'h0000FFFF, 32'h00007FFF));
    press(4'b0001, {2'b00, 16'h0000}, snap(3'd2, 1'b0, 4'h5, 32'h0000FFFF, 32'h00007FFF));
    press(4'b0001, {2'b01, 16'hAAAA}, snap(3'd3, 1'b0, 4'h5, 32'h0000FFFF, 32'hFFFFAAAA));
    press(4'b0011, {2'b00, 16'h0001}, snap(3'd0, 1'b0, 4'h0, 32'h00000000, 32'h00000000));

    // Reset in LOAD_OP with ENTER held through it
    press(4'b0001, {2'b10, 16'h0042}, snap(3'd2, 1'b0, 4'h0, 32'h00000042, 32'h00000000));
    press(4'b0001, {2'b10, 16'h0003}, snap(3'd4, 1'b0, 4'h0, 32'h00000042, 32'h00000003));
    sw = {2'b10, 16'h0099};
    exp_q.push_back(snap(3'd0, 1'b0, 4'h0, 32'h00000000, 32'h00000000));
    key[0] = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(snap(3'd2, 1'b0, 4'h0, 32'h00000099, 32'h00000000));
    repeat (30) @(posedge clk);
    #1;
    key = 4'hF;
    repeat (12) @(posedge clk);
    #1;

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_responses: got %0d outstanding, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
